// File: rtl/addr_trans_mc_pkg.sv
// addr_trans_mc shared definitions: exception codes, access types,
// DMW CSR field layout and the registered response bundle.
package addr_trans_mc_pkg;

    localparam logic [3:0] ECODE_NONE = 4'd0;
    localparam logic [3:0] ECODE_ALE  = 4'd1;
    localparam logic [3:0] ECODE_TLBR = 4'd2;
    localparam logic [3:0] ECODE_PIF  = 4'd3;
    localparam logic [3:0] ECODE_PIL  = 4'd4;
    localparam logic [3:0] ECODE_PIS  = 4'd5;
    localparam logic [3:0] ECODE_PPI  = 4'd6;
    localparam logic [3:0] ECODE_PME  = 4'd7;

    // Encoding 3 is reserved and behaves as a load
    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2,
        ACC_RSVD  = 2'd3
    } acc_t;

    // DMW layout: PLVn enable at bit n, MAT [5:4], PSEG [27:25], VSEG [31:29]
    localparam int DMW_PLV0    = 0;
    localparam int DMW_PLV3    = 3;
    localparam int DMW_MAT_LO  = 4;
    localparam int DMW_PSEG_LO = 25;
    localparam int DMW_VSEG_LO = 29;

    localparam logic [5:0] PS_HUGE = 6'd21;

    typedef struct packed {
        logic [31:0] paddr;
        logic [31:0] vaddr;
        logic        uncached;
        logic        excp;
        logic [3:0]  ecode;
    } atu_resp_t;

endpackage

// File: rtl/addr_trans_mc_atu_chan.sv
// atu_chan: one-entry translation stage for a single channel.
// Ports: CSR inputs (broadcast), req handshake + TLB search, resp handshake.
module atu_chan
    import addr_trans_mc_pkg::*;
#(
    parameter int NDMW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              crmd_da,
    input  logic              crmd_pg,
    input  logic [1:0]        crmd_plv,
    input  logic [1:0]        crmd_datf,
    input  logic [1:0]        crmd_datm,
    input  logic [9:0]        asid,
    input  logic [NDMW*32-1:0] dmw,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_vaddr,
    input  logic [1:0]        req_type,
    input  logic [1:0]        req_size,
    output logic [18:0]       tlb_s_vppn,
    output logic              tlb_s_odd,
    output logic [9:0]        tlb_s_asid,
    input  logic              tlb_found,
    input  logic              tlb_v,
    input  logic              tlb_d,
    input  logic [19:0]       tlb_ppn,
    input  logic [5:0]        tlb_ps,
    input  logic [1:0]        tlb_mat,
    input  logic [1:0]        tlb_plv,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_paddr,
    output logic [31:0]       resp_vaddr,
    output logic              resp_uncached,
    output logic              resp_excp,
    output logic [3:0]        resp_ecode
);

    acc_t        acc;
    logic        direct;
    logic        misalign;
    logic        dmw_hit;
    logic [31:0] win;
    logic [31:0] paddr;
    logic [1:0]  mat;
    logic [3:0]  ecode;
    logic        accept;
    logic        valid_q;
    atu_resp_t   resp_q;
    logic        unused_dmw;

    assign acc        = acc_t'(req_type);
    assign tlb_s_vppn = req_vaddr[31:13];
    assign tlb_s_odd  = req_vaddr[12];
    assign tlb_s_asid = asid;
    assign req_ready  = ~valid_q | resp_ready;
    assign accept     = req_valid & req_ready;
    assign unused_dmw = ^dmw;

    always_comb begin
        unique case (req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = req_vaddr[0];
            default: misalign = |req_vaddr[1:0];
        endcase
    end

    always_comb begin
        direct  = crmd_da | ~crmd_pg;
        dmw_hit = 1'b0;
        win     = '0;
        paddr   = req_vaddr;
        mat     = (acc == ACC_FETCH) ? crmd_datf : crmd_datm;
        ecode   = ECODE_NONE;
        if (!direct) begin
            // high-to-low scan: the lowest matching window is written last
            for (int w = NDMW - 1; w >= 0; w--) begin
                win = dmw[w*32 +: 32];
                if (win[DMW_VSEG_LO +: 3] == req_vaddr[31:29] &&
                    win[{3'b000, crmd_plv}]) begin
                    dmw_hit = 1'b1;
                    paddr   = {win[DMW_PSEG_LO +: 3], req_vaddr[28:0]};
                    mat     = win[DMW_MAT_LO +: 2];
                end
            end
            if (!dmw_hit) begin
                paddr = (tlb_ps == PS_HUGE)
                      ? {tlb_ppn[19:10], req_vaddr[21:0]}
                      : {tlb_ppn, req_vaddr[11:0]};
                mat   = tlb_mat;
                if (!tlb_found) begin
                    ecode = ECODE_TLBR;
                end else if (!tlb_v) begin
                    unique case (acc)
                        ACC_FETCH: ecode = ECODE_PIF;
                        ACC_STORE: ecode = ECODE_PIS;
                        default:   ecode = ECODE_PIL;
                    endcase
                end else if (crmd_plv > tlb_plv) begin
                    ecode = ECODE_PPI;
                end else if (acc == ACC_STORE && !tlb_d) begin
                    ecode = ECODE_PME;
                end
            end
        end
        if (misalign) ecode = ECODE_ALE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            resp_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (resp_ready) begin
                valid_q <= 1'b0;
            end
            if (accept && !flush) begin
                resp_q.paddr    <= paddr;
                resp_q.vaddr    <= req_vaddr;
                resp_q.uncached <= (mat == 2'd0);
                resp_q.excp     <= (ecode != ECODE_NONE);
                resp_q.ecode    <= ecode;
            end
        end
    end

    assign resp_valid    = valid_q;
    assign resp_paddr    = resp_q.paddr;
    assign resp_vaddr    = resp_q.vaddr;
    assign resp_uncached = resp_q.uncached;
    assign resp_excp     = resp_q.excp;
    assign resp_ecode    = resp_q.ecode;

endmodule

// File: rtl/addr_trans_mc.sv
// addr_trans_mc: NCH independent address-translation stages (DA/DMW/TLB).
// Ports: CRMD/ASID/DMW CSRs, per-channel request, TLB search, response.
module addr_trans_mc
    import addr_trans_mc_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int NDMW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               crmd_da,
    input  logic               crmd_pg,
    input  logic [1:0]         crmd_plv,
    input  logic [1:0]         crmd_datf,
    input  logic [1:0]         crmd_datm,
    input  logic [9:0]         asid,
    input  logic [NDMW*32-1:0] dmw,
    input  logic [NCH-1:0]     req_valid,
    output logic [NCH-1:0]     req_ready,
    input  logic [NCH*32-1:0]  req_vaddr,
    input  logic [NCH*2-1:0]   req_type,
    input  logic [NCH*2-1:0]   req_size,
    output logic [NCH*19-1:0]  tlb_s_vppn,
    output logic [NCH-1:0]     tlb_s_odd,
    output logic [NCH*10-1:0]  tlb_s_asid,
    input  logic [NCH-1:0]     tlb_found,
    input  logic [NCH-1:0]     tlb_v,
    input  logic [NCH-1:0]     tlb_d,
    input  logic [NCH*20-1:0]  tlb_ppn,
    input  logic [NCH*6-1:0]   tlb_ps,
    input  logic [NCH*2-1:0]   tlb_mat,
    input  logic [NCH*2-1:0]   tlb_plv,
    output logic [NCH-1:0]     resp_valid,
    input  logic [NCH-1:0]     resp_ready,
    output logic [NCH*32-1:0]  resp_paddr,
    output logic [NCH*32-1:0]  resp_vaddr,
    output logic [NCH-1:0]     resp_uncached,
    output logic [NCH-1:0]     resp_excp,
    output logic [NCH*4-1:0]   resp_ecode
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        atu_chan #(
            .NDMW(NDMW)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .flush        (flush),
            .crmd_da      (crmd_da),
            .crmd_pg      (crmd_pg),
            .crmd_plv     (crmd_plv),
            .crmd_datf    (crmd_datf),
            .crmd_datm    (crmd_datm),
            .asid         (asid),
            .dmw          (dmw),
            .req_valid    (req_valid[c]),
            .req_ready    (req_ready[c]),
            .req_vaddr    (req_vaddr[c*32 +: 32]),
            .req_type     (req_type[c*2 +: 2]),
            .req_size     (req_size[c*2 +: 2]),
            .tlb_s_vppn   (tlb_s_vppn[c*19 +: 19]),
            .tlb_s_odd    (tlb_s_odd[c]),
            .tlb_s_asid   (tlb_s_asid[c*10 +: 10]),
            .tlb_found    (tlb_found[c]),
            .tlb_v        (tlb_v[c]),
            .tlb_d        (tlb_d[c]),
            .tlb_ppn      (tlb_ppn[c*20 +: 20]),
            .tlb_ps       (tlb_ps[c*6 +: 6]),
            .tlb_mat      (tlb_mat[c*2 +: 2]),
            .tlb_plv      (tlb_plv[c*2 +: 2]),
            .resp_valid   (resp_valid[c]),
            .resp_ready   (resp_ready[c]),
            .resp_paddr   (resp_paddr[c*32 +: 32]),
            .resp_vaddr   (resp_vaddr[c*32 +: 32]),
            .resp_uncached(resp_uncached[c]),
            .resp_excp    (resp_excp[c]),
            .resp_ecode   (resp_ecode[c*4 +: 4])
        );
    end

endmodule

// File: tb/tb_addr_trans_mc.sv
// tb_addr_trans_mc: vector table, corner-case sequences and a
// randomized run checked against a spec-level translation model.
module tb_addr_trans_mc;

    localparam int NCH  = 2;
    localparam int NDMW = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               flush = 1'b0;
    logic               crmd_da = 1'b1;
    logic               crmd_pg = 1'b0;
    logic [1:0]         crmd_plv = '0;
    logic [1:0]         crmd_datf = '0;
    logic [1:0]         crmd_datm = '0;
    logic [9:0]         asid = 10'h2A5;
    logic [NDMW*32-1:0] dmw = '0;
    logic [NCH-1:0]     req_valid = '0;
    logic [NCH-1:0]     req_ready;
    logic [NCH*32-1:0]  req_vaddr = '0;
    logic [NCH*2-1:0]   req_type = '0;
    logic [NCH*2-1:0]   req_size = '0;
    logic [NCH*19-1:0]  tlb_s_vppn;
    logic [NCH-1:0]     tlb_s_odd;
    logic [NCH*10-1:0]  tlb_s_asid;
    logic [NCH-1:0]     tlb_found = '0;
    logic [NCH-1:0]     tlb_v = '0;
    logic [NCH-1:0]     tlb_d = '0;
    logic [NCH*20-1:0]  tlb_ppn = '0;
    logic [NCH*6-1:0]   tlb_ps = '0;
    logic [NCH*2-1:0]   tlb_mat = '0;
    logic [NCH*2-1:0]   tlb_plv = '0;
    logic [NCH-1:0]     resp_valid;
    logic [NCH-1:0]     resp_ready = '1;
    logic [NCH*32-1:0]  resp_paddr;
    logic [NCH*32-1:0]  resp_vaddr;
    logic [NCH-1:0]     resp_uncached;
    logic [NCH-1:0]     resp_excp;
    logic [NCH*4-1:0]   resp_ecode;

    addr_trans_mc #(.NCH(NCH), .NDMW(NDMW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .crmd_da(crmd_da), .crmd_pg(crmd_pg), .crmd_plv(crmd_plv),
        .crmd_datf(crmd_datf), .crmd_datm(crmd_datm), .asid(asid),
        .dmw(dmw), .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_type(req_type), .req_size(req_size),
        .tlb_s_vppn(tlb_s_vppn), .tlb_s_odd(tlb_s_odd),
        .tlb_s_asid(tlb_s_asid), .tlb_found(tlb_found), .tlb_v(tlb_v),
        .tlb_d(tlb_d), .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps),
        .tlb_mat(tlb_mat), .tlb_plv(tlb_plv), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_paddr(resp_paddr),
        .resp_vaddr(resp_vaddr), .resp_uncached(resp_uncached),
        .resp_excp(resp_excp), .resp_ecode(resp_ecode)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        da, pg;
        bit [1:0]  plv, datf, datm;
        bit [31:0] dmw0, dmw1;
        bit [1:0]  typ, size;
        bit [31:0] vaddr;
        bit        found, v, d;
        bit [19:0] ppn;
        bit [5:0]  ps;
        bit [1:0]  mat, tplv;
    } stim_t;

    typedef struct {
        bit [31:0] paddr;
        bit        unc, excp;
        bit [3:0]  ecode;
        bit        chk_pa;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic stim_t mk(bit da, bit [1:0] plv, bit [31:0] d0,
                                 bit [31:0] d1, bit [1:0] typ, bit [1:0] sz,
                                 bit [31:0] va, bit fnd, bit v, bit d,
                                 bit [19:0] ppn, bit [5:0] ps,
                                 bit [1:0] mat, bit [1:0] tplv);
        stim_t s;
        s.da = da; s.pg = !da; s.plv = plv; s.datf = 2'd0; s.datm = 2'd1;
        s.dmw0 = d0; s.dmw1 = d1; s.typ = typ; s.size = sz; s.vaddr = va;
        s.found = fnd; s.v = v; s.d = d; s.ppn = ppn; s.ps = ps;
        s.mat = mat; s.tplv = tplv;
        return s;
    endfunction

    function automatic exp_t mke(bit [31:0] pa, bit unc, bit ex,
                                 bit [3:0] ec, bit cp);
        exp_t e;
        e.paddr = pa; e.unc = unc; e.excp = ex; e.ecode = ec; e.chk_pa = cp;
        return e;
    endfunction

    // Reference translation derived directly from the architectural rules
    function automatic exp_t model(stim_t s);
        exp_t      e;
        bit [31:0] win;
        bit [31:0] mask;
        bit [1:0]  mat;
        int        hit;
        int        lowb;
        int        align;
        e = mke(32'h0, 1'b0, 1'b0, 4'd0, 1'b1);
        hit = -1;
        align = (s.size == 0) ? 1 : (s.size == 1) ? 2 : 4;
        if (s.da || !s.pg) begin
            e.paddr = s.vaddr;
            mat = (s.typ == 0) ? s.datf : s.datm;
        end else begin
            for (int w = 0; w < NDMW; w++) begin
                win = (w == 0) ? s.dmw0 : s.dmw1;
                if (hit < 0 && win[31:29] == s.vaddr[31:29] &&
                    win[{3'b000, s.plv}]) hit = w;
            end
            if (hit >= 0) begin
                win = (hit == 0) ? s.dmw0 : s.dmw1;
                e.paddr = {win[27:25], s.vaddr[28:0]};
                mat = win[5:4];
            end else begin
                lowb = (s.ps == 21) ? 22 : 12;
                mask = (32'd1 << lowb) - 32'd1;
                e.paddr = ({s.ppn, 12'h000} & ~mask) | (s.vaddr & mask);
                mat = s.mat;
                if (!s.found) e.ecode = 4'd2;
                else if (!s.v) e.ecode = (s.typ == 0) ? 4'd3 :
                                         (s.typ == 2) ? 4'd5 : 4'd4;
                else if (s.plv > s.tplv) e.ecode = 4'd6;
                else if (s.typ == 2 && !s.d) e.ecode = 4'd7;
            end
        end
        if ((s.vaddr % align) != 0) e.ecode = 4'd1;
        e.unc = (mat == 2'd0);
        e.excp = (e.ecode != 0);
        e.chk_pa = !e.excp;
        return e;
    endfunction

    task automatic drive(int ch, stim_t s);
        crmd_da = s.da; crmd_pg = s.pg; crmd_plv = s.plv;
        crmd_datf = s.datf; crmd_datm = s.datm; dmw = {s.dmw1, s.dmw0};
        req_vaddr[ch*32 +: 32] = s.vaddr;
        req_type[ch*2 +: 2] = s.typ;
        req_size[ch*2 +: 2] = s.size;
        tlb_found[ch] = s.found; tlb_v[ch] = s.v; tlb_d[ch] = s.d;
        tlb_ppn[ch*20 +: 20] = s.ppn;
        tlb_ps[ch*6 +: 6] = s.ps;
        tlb_mat[ch*2 +: 2] = s.mat;
        tlb_plv[ch*2 +: 2] = s.tplv;
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        s.da = ($urandom_range(0, 3) == 0);
        s.pg = s.da ? 1'b0 : ($urandom_range(0, 7) != 0);
        s.plv = 2'($urandom); s.datf = 2'($urandom); s.datm = 2'($urandom);
        s.dmw0 = {3'($urandom_range(4, 5)), 1'b0, 3'($urandom),
                  19'($urandom), 2'($urandom), 4'($urandom)};
        s.dmw1 = {3'($urandom_range(4, 5)), 1'b0, 3'($urandom),
                  19'($urandom), 2'($urandom), 4'($urandom)};
        s.vaddr = $urandom;
        if ($urandom_range(0, 1) == 1) s.vaddr[31:29] = 3'($urandom_range(4, 5));
        if ($urandom_range(0, 3) != 0) s.vaddr[1:0] = 2'b00;
        s.typ = 2'($urandom); s.size = 2'($urandom_range(0, 2));
        s.found = ($urandom_range(0, 4) != 0);
        s.v = ($urandom_range(0, 4) != 0);
        s.d = 1'($urandom);
        s.ppn = 20'($urandom);
        case ($urandom_range(0, 2))
            0: s.ps = 6'd12;
            1: s.ps = 6'd21;
            default: s.ps = 6'($urandom);
        endcase
        s.mat = 2'($urandom); s.tplv = 2'($urandom);
        return s;
    endfunction

    vec_t  vq[$];
    stim_t st[NCH];
    stim_t base;
    bit    mval[NCH];
    exp_t  mexp[NCH];
    bit [31:0] mva[NCH];

    localparam bit [31:0] D0 = 32'h8000_0011;

    task automatic add(stim_t s, exp_t e);
        vec_t v;
        v.s = s; v.e = e;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        add(mk(1,0,0,0, 0,2,32'h1C000000, 0,0,0,20'h0,12,0,0), mke(32'h1C000000,1,0,0,1));
        add(mk(1,0,0,0, 1,2,32'h1C000004, 0,0,0,20'h0,12,0,0), mke(32'h1C000004,0,0,0,1));
        add(mk(0,0,D0,0, 1,2,32'h90001234, 0,0,0,20'h0,12,0,0), mke(32'h10001234,0,0,0,1));
        add(mk(0,3,D0,0, 1,2,32'h90001234, 1,1,1,20'h00ABC,12,1,3), mke(32'h00ABC234,0,0,0,1));
        add(mk(0,0,D0,0, 2,2,32'h00400ABC, 1,1,0,20'h12345,12,1,0), mke(0,0,1,7,0));
        add(mk(0,0,D0,0, 1,2,32'h00400ABC, 1,1,1,20'h12345,21,1,0), mke(32'h12000ABC,0,0,0,1));
        add(mk(0,0,D0,0, 1,2,32'h00400AB2, 0,0,0,20'h12345,12,1,0), mke(0,0,1,1,0));
        add(mk(0,0,D0,0, 1,2,32'h00400AB0, 0,0,0,20'h12345,12,1,0), mke(0,0,1,2,0));
        add(mk(0,0,D0,0, 0,2,32'h00400AB0, 1,0,1,20'h12345,12,1,0), mke(0,0,1,3,0));
        add(mk(0,0,D0,0, 1,2,32'h00400AB0, 1,0,1,20'h12345,12,1,0), mke(0,0,1,4,0));
        add(mk(0,0,D0,0, 2,2,32'h00400AB0, 1,0,0,20'h12345,12,1,0), mke(0,0,1,5,0));
        add(mk(0,0,D0,0, 3,2,32'h00400AB0, 1,0,1,20'h12345,12,1,0), mke(0,0,1,4,0));
        add(mk(0,3,D0,0, 2,2,32'h00400ABC, 1,1,0,20'h12345,12,1,0), mke(0,0,1,6,0));
        add(mk(0,0,D0,0, 1,2,32'h00400AB0, 1,1,1,20'h12345,12,0,0), mke(32'h12345AB0,1,0,0,1));
        add(mk(0,0,D0,0, 2,1,32'h90000001, 0,0,0,20'h12345,12,1,0), mke(0,0,1,1,0));
        add(mk(0,3,D0,32'h82000028, 1,2,32'h90001234, 0,0,0,20'h0,12,0,0), mke(32'h30001234,0,0,0,1));
        add(mk(0,0,D0,32'h82000009, 1,2,32'h90001234, 0,0,0,20'h0,12,0,0), mke(32'h10001234,0,0,0,1));
        add(mk(0,0,D0,0, 1,2,32'h00400ABC, 1,1,1,20'h12345,14,1,0), mke(32'h12345ABC,0,0,0,1));
        add(mk(0,0,D0,0, 1,0,32'h00400AB3, 1,1,1,20'h12345,12,1,0), mke(32'h12345AB3,0,0,0,1));
        add(mk(0,0,D0,0, 1,1,32'h00400AB2, 1,1,1,20'h12345,12,1,0), mke(32'h12345AB2,0,0,0,1));
        add(mk(1,0,0,0, 0,2,32'h1C000002, 0,0,0,20'h0,12,0,0), mke(0,0,1,1,0));

        // reset state
        repeat (3) tick();
        chk("rst valid", 64'(resp_valid), 64'(0));
        chk("rst paddr", 64'(resp_paddr), 64'(0));
        chk("rst vaddr", 64'(resp_vaddr), 64'(0));
        chk("rst excp/ecode/unc",
            64'({resp_excp, resp_ecode, resp_uncached}), 64'(0));
        reset = 1'b1;
        tick();
        chk("rst ready", 64'(req_ready), 64'(2'b11));

        // vector table, alternating channels
        foreach (vq[i]) begin
            automatic int ch = i % NCH;
            drive(ch, vq[i].s);
            req_valid = '0;
            req_valid[ch] = 1'b1;
            #1;
            chk($sformatf("vec%0d ready", i), 64'(req_ready[ch]), 64'(1));
            chk($sformatf("vec%0d key", i),
                64'({tlb_s_vppn[ch*19 +: 19], tlb_s_odd[ch], tlb_s_asid[ch*10 +: 10]}),
                64'({vq[i].s.vaddr[31:12], asid}));
            @(posedge clk);
            #1;
            req_valid = '0;
            chk($sformatf("vec%0d valid", i), 64'(resp_valid), 64'(2'b01 << ch));
            chk($sformatf("vec%0d vaddr", i), 64'(resp_vaddr[ch*32 +: 32]),
                64'(vq[i].s.vaddr));
            chk($sformatf("vec%0d excp/ecode", i),
                64'({resp_excp[ch], resp_ecode[ch*4 +: 4]}),
                64'({vq[i].e.excp, vq[i].e.ecode}));
            if (vq[i].e.chk_pa)
                chk($sformatf("vec%0d paddr/unc", i),
                    64'({resp_uncached[ch], resp_paddr[ch*32 +: 32]}),
                    64'({vq[i].e.unc, vq[i].e.paddr}));
        end
        tick();

        // backpressure then back-to-back on channel 0
        resp_ready = '0;
        drive(0, mk(1,0,0,0, 1,2,32'h11110000, 0,0,0,20'h0,12,0,0));
        req_valid = 2'b01;
        tick();
        chk("bp first valid", 64'(resp_valid[0]), 64'(1));
        drive(0, mk(1,0,0,0, 1,2,32'h22220000, 0,0,0,20'h0,12,0,0));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp stall%0d ready", k), 64'(req_ready[0]), 64'(0));
            tick();
            chk($sformatf("bp stall%0d hold", k),
                64'({resp_valid[0], resp_paddr[31:0]}), 64'({1'b1, 32'h11110000}));
        end
        resp_ready = '1;
        #1;
        chk("bp release ready", 64'(req_ready[0]), 64'(1));
        tick();
        chk("bp b2b second", 64'({resp_valid[0], resp_paddr[31:0]}),
            64'({1'b1, 32'h22220000}));
        drive(0, mk(1,0,0,0, 1,2,32'h33330000, 0,0,0,20'h0,12,0,0));
        tick();
        chk("bp b2b third", 64'({resp_valid[0], resp_paddr[31:0]}),
            64'({1'b1, 32'h33330000}));
        req_valid = '0;
        tick();
        chk("bp drained", 64'(resp_valid), 64'(0));

        // flush coincident with accept, then flush of full stages
        drive(0, mk(1,0,0,0, 1,2,32'h44440000, 0,0,0,20'h0,12,0,0));
        drive(1, mk(1,0,0,0, 1,2,32'h55550000, 0,0,0,20'h0,12,0,0));
        req_valid = 2'b11;
        flush = 1'b1;
        tick();
        chk("flush accept", 64'(resp_valid), 64'(0));
        flush = 1'b0;
        resp_ready = '0;
        tick();
        chk("flush fill", 64'(resp_valid), 64'(2'b11));
        req_valid = '0;
        flush = 1'b1;
        tick();
        chk("flush full", 64'(resp_valid), 64'(0));
        flush = 1'b0;
        resp_ready = '1;
        tick();

        // randomized run
        for (int c = 0; c < NCH; c++) mval[c] = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("rnd%0d ch%0d valid", cyc, c),
                    64'(resp_valid[c]), 64'(mval[c]));
                if (mval[c]) begin
                    chk($sformatf("rnd%0d ch%0d vaddr", cyc, c),
                        64'(resp_vaddr[c*32 +: 32]), 64'(mva[c]));
                    chk($sformatf("rnd%0d ch%0d excp/ecode", cyc, c),
                        64'({resp_excp[c], resp_ecode[c*4 +: 4]}),
                        64'({mexp[c].excp, mexp[c].ecode}));
                    if (mexp[c].chk_pa)
                        chk($sformatf("rnd%0d ch%0d paddr/unc", cyc, c),
                            64'({resp_uncached[c], resp_paddr[c*32 +: 32]}),
                            64'({mexp[c].unc, mexp[c].paddr}));
                end
            end
            base = rnd_stim();
            for (int c = 0; c < NCH; c++) begin
                st[c] = rnd_stim();
                st[c].da = base.da; st[c].pg = base.pg; st[c].plv = base.plv;
                st[c].datf = base.datf; st[c].datm = base.datm;
                st[c].dmw0 = base.dmw0; st[c].dmw1 = base.dmw1;
                drive(c, st[c]);
                req_valid[c] = ($urandom_range(0, 2) != 0);
                resp_ready[c] = ($urandom_range(0, 2) != 0);
            end
            flush = ($urandom_range(0, 15) == 0);
            #1;
            for (int c = 0; c < NCH; c++) begin
                automatic bit rdy = !mval[c] || resp_ready[c];
                chk($sformatf("rnd%0d ch%0d ready", cyc, c),
                    64'(req_ready[c]), 64'(rdy));
                if (flush) begin
                    mval[c] = 1'b0;
                end else if (req_valid[c] && rdy) begin
                    mval[c] = 1'b1;
                    mexp[c] = model(st[c]);
                    mva[c] = st[c].vaddr;
                end else if (resp_ready[c]) begin
                    mval[c] = 1'b0;
                end
            end
            tick();
        end
        req_valid = '0;
        flush = 1'b0;
        resp_ready = '1;
        tick();
        tick();

        // reset low mid-transaction
        resp_ready = '0;
        drive(0, mk(1,0,0,0, 1,2,32'h66660000, 0,0,0,20'h0,12,1,0));
        drive(1, mk(1,0,0,0, 1,2,32'h77770000, 0,0,0,20'h0,12,1,0));
        req_valid = 2'b11;
        tick();
        chk("rst2 fill", 64'(resp_valid), 64'(2'b11));
        req_valid = '0;
        reset = 1'b0;
        #1;
        chk("rst2 async valid", 64'(resp_valid), 64'(0));
        chk("rst2 async addr", 64'({resp_paddr, resp_vaddr}), 64'(0));
        tick();
        chk("rst2 held", 64'({resp_valid, resp_excp, resp_ecode, resp_uncached}),
            64'(0));
        reset = 1'b1;
        tick();
        chk("rst2 ready", 64'(req_ready), 64'(2'b11));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/addr_trans_mc.md
ADDR_TRANS_MC -- requirements
Module: addr_trans_mc

Interface
REQ-001 SHALL have parameters NCH (default 2, number of channels) and NDMW (default 2, number of DMW windows).
REQ-002 SHALL have ports, one per line:
  clk  in  1  sole clock
  reset  in  1  asynchronous, active-low reset
  flush  in  1  kill all in-flight translations
  crmd_da / crmd_pg  in  1 / 1  direct/paged mode
  crmd_plv  in  2  current privilege level
  crmd_datf / crmd_datm  in  2 / 2  direct-mode MAT for fetch/data
  asid  in  10  current ASID
  dmw  in  NDMW*32  DMW CSRs; bit0 = PLV0 enable, bit3 = PLV3 enable, [5:4] MAT, [27:25] PSEG, [31:29] VSEG
  req_valid / req_ready  in / out  NCH / NCH  per-channel request handshake
  req_vaddr  in  NCH*32  virtual address
  req_type  in  NCH*2  access type: 0 fetch, 1 load, 2 store
  req_size  in  NCH*2  access size: 0 byte, 1 half, 2 word
  tlb_s_vppn / tlb_s_odd / tlb_s_asid  out  NCH*19 / NCH / NCH*10  combinational TLB search keys
  tlb_found, tlb_v, tlb_d  in  NCH each  TLB search results, same cycle
  tlb_ppn, tlb_ps, tlb_mat, tlb_plv  in  NCH*20, NCH*6, NCH*2, NCH*2  TLB search results, same cycle
  resp_valid / resp_ready  out / in  NCH / NCH  per-channel response handshake
  resp_paddr / resp_vaddr  out  NCH*32 each  translated and original address
  resp_uncached  out  NCH  MAT == 0
  resp_excp / resp_ecode  out  NCH / NCH*4  exception flag and code

Function
REQ-003 Each channel SHALL be an independent one-entry stage; channels SHALL NOT interact.
REQ-004 req_ready SHALL be !resp_valid | resp_ready, so a full stage accepts a new request in the same cycle its response fires.
REQ-005 On accept (req_valid & req_ready), the stage SHALL capture vaddr plus all translation results; response latency SHALL be exactly 1 cycle.
REQ-006 tlb_s_* SHALL be driven from req_vaddr[31:13], req_vaddr[12] and asid every cycle.
REQ-007 Mode selection SHALL be as follows:
  - DA=1: paddr = vaddr; MAT = datf (fetch) or datm (load/store).
  - PG=1: the lowest-index DMW window with VSEG match and its crmd_plv enable bit set wins, giving paddr = {PSEG, vaddr[28:0]} and MAT = window MAT.
  - PG=1 with no window hit: TLB path.
REQ-008 On the TLB path, ps == 21 SHALL give paddr = {ppn[19:10], vaddr[21:0]}; otherwise paddr = {ppn, vaddr[11:0]}.
REQ-009 Exception priority SHALL be ALE > TLBR > PIF/PIL/PIS > PPI > PME; ecodes are ALE=1, TLBR=2, PIF=3, PIL=4, PIS=5, PPI=6, PME=7.
  - ALE: misaligned half or word access.
  - TLBR: !found.
  - PIF/PIL/PIS: !v, selected by req_type.
  - PPI: crmd_plv > tlb_plv.
  - PME: store with !d.
REQ-010 TLB-derived exceptions SHALL apply only on the TLB path; DA and DMW hits SHALL raise ALE only.
REQ-011 resp_excp=1 SHALL still return resp_vaddr; resp_paddr SHALL then be don't-care.
REQ-012 flush SHALL clear resp_valid of every channel next edge and SHALL override a same-cycle accept.
REQ-013 req_type 3 SHALL be treated as load.

Reset
REQ-014 While reset is low, resp_valid SHALL be 0 and resp_excp, resp_ecode, resp_uncached, resp_paddr, resp_vaddr SHALL be 0; req_ready SHALL be 1 after reset release.

Structure
REQ-015 Ecode constants, the access-type encoding and the DMW field positions SHALL live in the shared defines package.
REQ-016 Per-channel logic SHALL be one sub-module atu_chan, instantiated NCH times with DMW/CSR inputs broadcast.

Verification
REQ-017 The bench SHALL cover:
  - DA=1, datf=0, fetch 0x1C000000 -> paddr 0x1C000000, uncached=1, one cycle later.
  - PG=1, plv=0, dmw0=0x80000011, load 0x9000_1234 -> paddr 0x1000_1234, uncached=0; same with plv=3 -> TLB path.
  - PG=1, TLB found, ps=12, ppn=0x12345, v=1, d=0, store 0x0040_0ABC -> PME ecode 7; ps=21 load -> paddr {ppn[19:10], vaddr[21:0]}.
  - Word load at 0x...2 with TLB miss -> ALE (1), not TLBR.
  - resp_ready=0 for 3 cycles -> req_ready=0, response held stable; release with new request pending -> back-to-back responses, no bubble.
  - flush coincident with accept, and reset low mid-transaction -> resp_valid=0 next cycle on all channels.
